// File: rtl/vit_pkg.sv
// Shared definitions for the K=4 convolutional encoder and the Viterbi decoder blocks.
// Build option CONV_ENC_TAIL_EN adds the zero-tail flush state to the encoder FSM.
package vit_pkg;

   localparam int K        = 4;
   localparam int STATE_W  = 3;
   localparam int TAIL_LEN = STATE_W;

   localparam logic [K-1:0] G0_DEF = 4'b1111;
   localparam logic [K-1:0] G1_DEF = 4'b1101;

   typedef logic [STATE_W-1:0] state_t;

`ifdef CONV_ENC_TAIL_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } enc_fsm_e;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1
   } enc_fsm_e;
`endif

   // Generator bit K-1 taps the input bit; bit k below it taps s[STATE_W-1-k].
   function automatic logic [K-1:0] tap_vec(input logic b, input state_t s);
      logic [K-1:0] v;
      v[K-1] = b;
      for (int k = 0; k < STATE_W; k++) begin
         v[k] = s[STATE_W-1-k];
      end
      return v;
   endfunction

endpackage

// File: rtl/conv_enc_step.sv
// One trellis branch of the rate-1/2 encoder: (b, s) -> coded symbol {y1,y0} and next state.
// Purely combinational so the decoder's branch-metric model can reuse it.
module conv_enc_step
   import vit_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEF,
   parameter logic [K-1:0] G1 = G1_DEF
) (
   input  logic       i_b,
   input  state_t     i_s,
   output logic [1:0] o_sym,
   output state_t     o_s_nxt
);

   logic [K-1:0] w_taps;

   assign w_taps  = tap_vec(i_b, i_s);
   assign o_sym   = {^(w_taps & G1), ^(w_taps & G0)};
   assign o_s_nxt = {i_s[STATE_W-2:0], i_b};

endmodule

// File: rtl/conv_enc.sv
// Streaming rate-1/2 K=4 convolutional encoder with a registered ready/valid output stage.
// Define CONV_ENC_TAIL_EN to flush each frame with three zero tail bits (out_last on the last tail symbol).
module conv_enc
   import vit_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEF,
   parameter logic [K-1:0] G1 = G1_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_data,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_sym,
   output logic       out_last
);

   enc_fsm_e   r_state, w_state_nxt;
   state_t     r_s, w_s_nxt;
   logic       r_out_valid, w_out_valid_nxt;
   logic [1:0] r_out_sym, w_out_sym_nxt;
   logic       r_out_last, w_out_last_nxt;
`ifdef CONV_ENC_TAIL_EN
   logic [1:0] r_tail_cnt, w_tail_cnt_nxt;
`endif

   logic       w_load;
   logic       w_in_fire;
   logic       w_step_b;
   logic [1:0] w_step_sym;
   state_t     w_step_s;

   // The output register may take a new symbol when it is empty or being drained this cycle.
   assign w_load    = !r_out_valid || out_ready;
   assign in_ready  = ((r_state == IDLE) || (r_state == DATA)) && w_load;
   assign w_in_fire = in_valid && in_ready;

`ifdef CONV_ENC_TAIL_EN
   assign w_step_b = (r_state == TAIL) ? 1'b0 : in_data;
`else
   assign w_step_b = in_data;
`endif

   conv_enc_step #(
      .G0 (G0),
      .G1 (G1)
   ) u_step (
      .i_b     (w_step_b),
      .i_s     (r_s),
      .o_sym   (w_step_sym),
      .o_s_nxt (w_step_s)
   );

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      w_state_nxt     = r_state;
      w_s_nxt         = r_s;
      w_out_valid_nxt = r_out_valid;
      w_out_sym_nxt   = r_out_sym;
      w_out_last_nxt  = r_out_last;
`ifdef CONV_ENC_TAIL_EN
      w_tail_cnt_nxt  = r_tail_cnt;
`endif
      if (w_load) begin
         w_out_valid_nxt = 1'b0;
         w_out_last_nxt  = 1'b0;
      end

      case (r_state)
         IDLE, DATA: begin
            if (w_in_fire) begin
               w_out_valid_nxt = 1'b1;
               w_out_sym_nxt   = w_step_sym;
               w_s_nxt         = w_step_s;
               if (in_last) begin
`ifdef CONV_ENC_TAIL_EN
                  w_state_nxt    = TAIL;
`else
                  w_state_nxt    = IDLE;
                  w_s_nxt        = '0;
                  w_out_last_nxt = 1'b1;
`endif
               end else begin
                  w_state_nxt = DATA;
               end
            end
         end
`ifdef CONV_ENC_TAIL_EN
         TAIL: begin
            // Returning to IDLE as the last tail symbol is loaded lets the next frame start on its drain cycle.
            if (w_load) begin
               w_out_valid_nxt = 1'b1;
               w_out_sym_nxt   = w_step_sym;
               w_s_nxt         = w_step_s;
               if (r_tail_cnt == 2'(TAIL_LEN - 1)) begin
                  w_out_last_nxt = 1'b1;
                  w_state_nxt    = IDLE;
                  w_tail_cnt_nxt = 2'd0;
               end else begin
                  w_tail_cnt_nxt = r_tail_cnt + 2'd1;
               end
            end
         end
`endif
         default: begin
            w_state_nxt = IDLE;
            w_s_nxt     = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state     <= IDLE;
         r_s         <= '0;
         r_out_valid <= 1'b0;
         r_out_sym   <= 2'b00;
         r_out_last  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
         r_tail_cnt  <= 2'd0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_s         <= w_s_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_sym   <= w_out_sym_nxt;
         r_out_last  <= w_out_last_nxt;
`ifdef CONV_ENC_TAIL_EN
         r_tail_cnt  <= w_tail_cnt_nxt;
`endif
      end
   end

   assign out_valid = r_out_valid;
   assign out_sym   = r_out_sym;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_conv_enc.sv
// Self-checking bench for conv_enc: convolution-sum reference model, scoreboard and directed frames.
// Follows the build option CONV_ENC_TAIL_EN in the same way as the RTL.
module tb_conv_enc;
   import vit_pkg::*;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_sym;
   logic       out_last;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ready_mode = 3;  // 0: always 1, 1: toggle, 2: random, 3: hold 0
   int first_acc_cyc = -1;
   int last_out_cyc  = -1;

   logic       m_hist[$];   // bits of the open frame, oldest first
   logic [3:0] exp_q[$];    // expected {is_tail, last, y1, y0}
   logic [2:0] rx_log[$];   // observed {last, y1, y0}
   logic [2:0] ref_log[$];

   logic       prev_stall = 1'b0;
   logic [2:0] prev_out   = 3'b000;

`ifdef CONV_ENC_TAIL_EN
   localparam int IMP_N = 4;
   // Impulse response reads each generator MSB-first: y0 = 1,1,1,1 and y1 = 1,1,0,1.
   logic [2:0] imp_exp [IMP_N] = '{3'b011, 3'b011, 3'b001, 3'b111};
   localparam int B2B_IDX = 5;
`else
   localparam int IMP_N = 1;
   logic [2:0] imp_exp [IMP_N] = '{3'b111};
   localparam int B2B_IDX = 2;
`endif

   conv_enc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sym   (out_sym),
      .out_last  (out_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // y_j(t) = XOR over k of G_j[K-1-k] * x(t-k), with x = 0 before the frame started.
   function automatic logic [1:0] model_y();
      int   t = m_hist.size() - 1;
      logic y0 = 1'b0;
      logic y1 = 1'b0;
      for (int k = 0; k < K; k++) begin
         if (t - k >= 0) begin
            y0 ^= G0_DEF[K-1-k] & m_hist[t-k];
            y1 ^= G1_DEF[K-1-k] & m_hist[t-k];
         end
      end
      return {y1, y0};
   endfunction

   task automatic model_push(input logic b, input logic last);
      m_hist.push_back(b);
`ifdef CONV_ENC_TAIL_EN
      exp_q.push_back({1'b0, 1'b0, model_y()});
      if (last) begin
         for (int j = 0; j < K - 1; j++) begin
            m_hist.push_back(1'b0);
            exp_q.push_back({1'b1, (j == K - 2), model_y()});
         end
         m_hist.delete();
      end
`else
      exp_q.push_back({1'b0, last, model_y()});
      if (last) m_hist.delete();
`endif
   endtask

   // out_ready pattern generator, updated a little after each rising edge
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Output monitor / scoreboard, sampling on the falling edge
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", 32'(out_valid), 32'd1);
               check("stall_data", 32'({out_last, out_sym}), 32'(prev_out));
            end
            if (out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
`ifdef CONV_ENC_TAIL_EN
            if (exp_q.size() >= 2 && exp_q[exp_q.size()-1][3])
               check("in_ready_in_tail", 32'(in_ready), 32'd0);
`endif
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("spurious_sym", 32'(exp_q.size()), 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("out_sym", 32'(out_sym), 32'(e[1:0]));
                  check("out_last", 32'(out_last), 32'(e[2]));
               end
               rx_log.push_back({out_last, out_sym});
               if (out_last) last_out_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_last, out_sym};
         end
      end
   end

   task automatic do_reset(input int cycles);
      ready_mode = 3;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      in_data    = 1'b0;
      exp_q.delete();
      m_hist.delete();
      repeat (cycles) @(posedge clk);
      #1;
      rst        = 1'b0;
      ready_mode = 0;
   endtask

   // Bits go MSB-first from data[n-1]; gap is the percentage of idle in_valid cycles.
   task automatic send_frame(input int n, input logic [63:0] data, input int gap, input logic with_last);
      for (int i = 0; i < n; i++) begin
         bit   acc    = 1'b0;
         int   waited = 0;
         logic b      = data[n-1-i];
         logic l      = with_last && (i == n - 1);
         while (!acc) begin
            in_valid = (int'($urandom_range(99)) >= gap);
            in_data  = b;
            in_last  = l;
            @(negedge clk);
            if (in_valid && in_ready) begin
               acc = 1'b1;
               model_push(b, l);
               if (i == 0) first_acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            waited++;
            if (!acc && waited > 300) begin
               check("in_accept_timeout", 32'(waited), 32'd0);
               acc = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_done", 32'(n < 2000), 32'd1);
   endtask

   task automatic check_impulse(input string tag);
      check({tag, "_len"}, 32'(rx_log.size()), 32'(IMP_N));
      for (int i = 0; i < IMP_N && i < rx_log.size(); i++)
         check(tag, 32'(rx_log[i]), 32'(imp_exp[i]));
   endtask

   initial begin
      logic [3:0] e;
      in_valid = 1'b0;
      in_data  = 1'b0;
      in_last  = 1'b0;
      rst      = 1'b1;

      // reset state
      do_reset(3);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sym", 32'(out_sym), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // pin the reference model to the hand-computed impulse response
      model_push(1'b1, 1'b1);
      check("pin_model_len", 32'(exp_q.size()), 32'(IMP_N));
      for (int i = 0; i < IMP_N && exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         check("pin_model", 32'(e[2:0]), 32'(imp_exp[i]));
      end
      exp_q.delete();

      // impulse frame, then the same frame again from the idle state
      rx_log.delete();
      send_frame(1, 64'd1, 0, 1'b1);
      wait_drain();
      check_impulse("impulse");
      check("idle_in_ready", 32'(in_ready), 32'd1);
      rx_log.delete();
      send_frame(1, 64'd1, 0, 1'b1);
      wait_drain();
      check_impulse("impulse_again");

      // backpressure: identical stream with and without stalls
      rx_log.delete();
      send_frame(8, 64'b10110010, 0, 1'b1);
      wait_drain();
      ref_log = rx_log;
      rx_log.delete();
      ready_mode = 1;
      send_frame(8, 64'b10110010, 0, 1'b1);
      wait_drain();
      ready_mode = 0;
      check("bp_len", 32'(rx_log.size()), 32'(ref_log.size()));
      for (int i = 0; i < rx_log.size() && i < ref_log.size(); i++)
         check("bp_stream", 32'(rx_log[i]), 32'(ref_log[i]));

      // back-to-back frames: second frame starts on the final symbol's drain cycle
      @(posedge clk);
      #1;
      rx_log.delete();
      send_frame(2, 64'b11, 0, 1'b1);
      send_frame(1, 64'b1, 0, 1'b1);
      check("b2b_start_cycle", 32'(first_acc_cyc), 32'(last_out_cyc));
      wait_drain();
      check("b2b_len", 32'(rx_log.size() > B2B_IDX), 32'd1);
      if (rx_log.size() > B2B_IDX) check("b2b_first_sym", 32'(rx_log[B2B_IDX][1:0]), 32'd3);

      // mid-frame reset after 3 of 8 bits
      send_frame(3, 64'b101, 0, 1'b0);
      do_reset(1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      rx_log.delete();
      send_frame(1, 64'd1, 0, 1'b1);
      wait_drain();
      check_impulse("post_rst_impulse");

      // random traffic: 4 frames of 64 bits with random gaps and backpressure
      ready_mode = 2;
      for (int f = 0; f < 4; f++)
         send_frame(64, {$urandom, $urandom}, 25, 1'b1);
      ready_mode = 0;
      wait_drain();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
